alu_bus_responder: RTL and testbench

//   Datapath-side ALU that responds to the control strobes issued by the

---
 rtl/alu_bus_responder_if.sv | 25 ++
 rtl/alu_bus_responder.sv | 110 +++++++++++
 tb/tb_alu_bus_responder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_bus_responder_if.sv
// alu_bus_responder_if: bus and control strobes between the sequencer FSMs and the datapath ALU.
interface alu_bus_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] bus_out;
    logic [3:0]       alu_op;
    logic             alu_in0;
    logic             alu_in1;
    logic             alu_out_latch;
    logic             alu_out_en;
    logic             bus_oe;
    logic             busy;
    logic             res_valid;
    logic             flag_z;
    logic             flag_c;
    logic             flag_n;
    logic             op_err;
    modport master (
        output bus_in, alu_op, alu_in0, alu_in1, alu_out_latch, alu_out_en,
        input  bus_out, bus_oe, busy, res_valid, flag_z, flag_c, flag_n, op_err
    );
    modport slave (
        input  bus_in, alu_op, alu_in0, alu_in1, alu_out_latch, alu_out_en,
        output bus_out, bus_oe, busy, res_valid, flag_z, flag_c, flag_n, op_err
    );
endinterface

// File: rtl/alu_bus_responder.sv
// alu_bus_responder: bus-strobed ALU with single-cycle logic/arith ops, iterative shifts/multiply and an output latch.
module alu_bus_responder #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4,
    parameter int MUL_EN  = 1
) (
    input logic      clk,
    input logic      rst,
    alu_bus_if.slave bus
);
    localparam int CW = SHAMT_W + 1;
    typedef enum logic [1:0] {IDLE, EXEC1, ITER, DONE} state_t;
    state_t state, nxt;
    logic [WIDTH-1:0]   a, b, sh, mr, res, z, ex_res, fin_res, sh_nxt, new_a, z_new;
    logic [2*WIDTH-1:0] acc, mc, mul_sum;
    logic [WIDTH:0]     add_r, sub_r;
    logic [3:0]         op;
    logic [CW-1:0]      cnt;
    logic [SHAMT_W-1:0] shamt_in;
    logic res_c, ex_c, ex_err, fin_c, sh_bit, fin, pend, start_iter, z_we, z_cn, z_ok, err, fz, fc, fn;
    assign new_a      = bus.alu_in0 ? bus.bus_in : a;
    assign shamt_in   = bus.bus_in[SHAMT_W-1:0];
    assign start_iter = (bus.alu_op == 4'd8 && MUL_EN != 0) ||
                        ((bus.alu_op == 4'd6 || bus.alu_op == 4'd7) && shamt_in != '0);
    assign add_r      = {1'b0, sh} + {1'b0, b};
    assign sub_r      = {1'b0, sh} - {1'b0, b};
    assign mul_sum    = acc + (mr[0] ? mc : '0);
    assign sh_nxt     = op == 4'd6 ? sh << 1 : sh >> 1;
    assign sh_bit     = op == 4'd6 ? sh[WIDTH-1] : sh[0];
    always_comb begin
        ex_res = '0;
        ex_c   = 1'b0;
        ex_err = 1'b0;
        case (op)
            4'd0:       {ex_c, ex_res} = add_r;
            4'd1:       begin ex_res = sub_r[WIDTH-1:0]; ex_c = ~sub_r[WIDTH]; end
            4'd2:       ex_res = sh & b;
            4'd3:       ex_res = sh | b;
            4'd4:       ex_res = sh ^ b;
            4'd5:       ex_res = ~sh;
            4'd6, 4'd7: ex_res = sh;
            default:    ex_err = 1'b1;
        endcase
    end
    assign fin     = state == EXEC1 || (state == ITER && cnt == CW'(1));
    assign fin_res = state == EXEC1 ? ex_res : op == 4'd8 ? mul_sum[WIDTH-1:0] : sh_nxt;
    assign fin_c   = state == EXEC1 ? ex_c : op == 4'd8 ? |mul_sum[2*WIDTH-1:WIDTH] : sh_bit;
    // A request made while busy completes on the finishing edge unless an abort restarts the op.
    assign z_we    = (bus.alu_out_latch && state == DONE) ||
                     (fin && !bus.alu_in1 && (pend || (bus.alu_out_latch && state == ITER)));
    assign z_new   = state == DONE ? res : fin_res;
    assign z_cn    = state == DONE ? res_c : fin_c;
    assign z_ok    = state == DONE ? !err : 1'b1;
    always_comb begin
        nxt = state;
        if (bus.alu_in1) nxt = start_iter ? ITER : EXEC1;
        else if (fin) nxt = DONE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= nxt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= '0; b <= '0; sh <= '0; mr <= '0; mc <= '0; acc <= '0; op <= '0; cnt <= '0;
            res <= '0; res_c <= 1'b0; err <= 1'b0; pend <= 1'b0;
            z <= '0; fz <= 1'b0; fc <= 1'b0; fn <= 1'b0;
        end else begin
            if (bus.alu_in0) a <= bus.bus_in;
            if (bus.alu_in1) begin
                b    <= bus.bus_in;
                op   <= bus.alu_op;
                sh   <= new_a;
                mr   <= bus.bus_in;
                mc   <= {{WIDTH{1'b0}}, new_a};
                acc  <= '0;
                cnt  <= bus.alu_op == 4'd8 ? CW'(WIDTH) : CW'(shamt_in);
                err  <= 1'b0;
                pend <= 1'b0;
            end else begin
                if (state == ITER) begin
                    sh  <= sh_nxt;
                    mr  <= mr >> 1;
                    mc  <= mc << 1;
                    acc <= mul_sum;
                    cnt <= cnt - 1'b1;
                end
                if (fin) begin
                    res   <= fin_res;
                    res_c <= fin_c;
                    err   <= state == EXEC1 && ex_err;
                    pend  <= 1'b0;
                end else if (bus.alu_out_latch && state == ITER) pend <= 1'b1;
            end
            if (z_we) begin
                z  <= z_new;
                fz <= z_ok && z_new == '0;
                fc <= z_cn;
                fn <= z_new[WIDTH-1];
            end
        end
    end
    assign bus.bus_out   = z;
    assign bus.bus_oe    = bus.alu_out_en;
    assign bus.busy      = state == ITER;
    assign bus.res_valid = state == DONE;
    assign bus.flag_z    = fz;
    assign bus.flag_c    = fc;
    assign bus.flag_n    = fn;
    assign bus.op_err    = err;
endmodule

// File: tb/tb_alu_bus_responder.sv
// tb_alu_bus_responder: directed scenarios for the bus ALU with hand-computed expected results.
module tb_alu_bus_responder;
    logic clk = 1'b0;
    logic rst;
    int   cmp = 0;
    int   bad = 0;
    alu_bus_if #(.WIDTH(16)) bif();
    alu_bus_responder #(.WIDTH(16), .SHAMT_W(4), .MUL_EN(1)) dut (.clk(clk), .rst(rst), .bus(bif.slave));
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic wr_a(input logic [15:0] v);
        bif.bus_in = v; bif.alu_in0 = 1'b1; cyc(); bif.alu_in0 = 1'b0;
    endtask
    task automatic start(input logic [15:0] v, input logic [3:0] o);
        bif.bus_in = v; bif.alu_op = o; bif.alu_in1 = 1'b1; cyc(); bif.alu_in1 = 1'b0;
    endtask
    task automatic latch();
        bif.alu_out_latch = 1'b1; cyc(); bif.alu_out_latch = 1'b0;
    endtask
    task automatic run_busy(input bit latch_first, output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            if (!bif.busy) break;
            n++;
            bif.alu_out_latch = latch_first && i == 0;
            cyc();
        end
        bif.alu_out_latch = 1'b0;
    endtask

    task automatic test_reset();
        cmp++; if (bif.bus_out !== 16'h0000) begin bad++; $display("FAIL reset_bus_out: got %h want 0000", bif.bus_out); end
        cmp++; if ({bif.busy, bif.res_valid, bif.op_err, bif.flag_z, bif.flag_c, bif.flag_n, bif.bus_oe} !== 7'b0)
            begin bad++; $display("FAIL reset_status: got %b want 0000000", {bif.busy, bif.res_valid, bif.op_err, bif.flag_z, bif.flag_c, bif.flag_n, bif.bus_oe}); end
    endtask

    task automatic test_add();
        wr_a(16'h0005);
        start(16'h0003, 4'd0);
        cmp++; if (bif.res_valid !== 1'b0) begin bad++; $display("FAIL add_valid_early: got %b want 0", bif.res_valid); end
        cyc();
        cmp++; if (bif.res_valid !== 1'b1) begin bad++; $display("FAIL add_valid: got %b want 1", bif.res_valid); end
        latch();
        bif.alu_out_en = 1'b1;
        #1;
        cmp++; if (bif.bus_out !== 16'h0008) begin bad++; $display("FAIL add_result: got %h want 0008", bif.bus_out); end
        cmp++; if (bif.bus_oe !== 1'b1) begin bad++; $display("FAIL add_oe: got %b want 1", bif.bus_oe); end
        cmp++; if ({bif.flag_z, bif.flag_c, bif.flag_n} !== 3'b000) begin bad++; $display("FAIL add_flags: got %b want 000", {bif.flag_z, bif.flag_c, bif.flag_n}); end
        bif.alu_out_en = 1'b0;
        cyc();
    endtask

    task automatic test_sub();
        wr_a(16'h0003);
        start(16'h0005, 4'd1);
        cyc();
        latch();
        cmp++; if (bif.bus_out !== 16'hFFFE) begin bad++; $display("FAIL sub_borrow_result: got %h want fffe", bif.bus_out); end
        cmp++; if ({bif.flag_z, bif.flag_c, bif.flag_n} !== 3'b001) begin bad++; $display("FAIL sub_borrow_flags: got %b want 001", {bif.flag_z, bif.flag_c, bif.flag_n}); end
        wr_a(16'h0005);
        start(16'h0005, 4'd1);
        cyc();
        latch();
        cmp++; if (bif.bus_out !== 16'h0000) begin bad++; $display("FAIL sub_eq_result: got %h want 0000", bif.bus_out); end
        cmp++; if ({bif.flag_z, bif.flag_c, bif.flag_n} !== 3'b110) begin bad++; $display("FAIL sub_eq_flags: got %b want 110", {bif.flag_z, bif.flag_c, bif.flag_n}); end
    endtask

    task automatic test_shift();
        int n = 0;
        wr_a(16'h8001);
        start(16'h0004, 4'd6);
        for (int i = 0; i < 40; i++) begin
            if (!bif.busy) break;
            n++;
            if (i > 0) begin
                cmp++; if (bif.bus_out !== 16'h0000) begin bad++; $display("FAIL shl_early_latch: got %h want 0000 at busy cycle %0d", bif.bus_out, i); end
            end
            bif.alu_out_latch = i == 0;
            bif.alu_in0 = i == 1;
            bif.bus_in = 16'hFFFF;
            cyc();
        end
        bif.alu_out_latch = 1'b0;
        bif.alu_in0 = 1'b0;
        cmp++; if (n !== 4) begin bad++; $display("FAIL shl_busy_cycles: got %0d want 4", n); end
        cmp++; if (bif.bus_out !== 16'h0010) begin bad++; $display("FAIL shl_result: got %h want 0010", bif.bus_out); end
        cmp++; if ({bif.flag_z, bif.flag_c, bif.flag_n} !== 3'b000) begin bad++; $display("FAIL shl_flags: got %b want 000", {bif.flag_z, bif.flag_c, bif.flag_n}); end
        cmp++; if (bif.res_valid !== 1'b1) begin bad++; $display("FAIL shl_valid: got %b want 1", bif.res_valid); end
    endtask

    task automatic test_mul();
        int n;
        wr_a(16'h0100);
        start(16'h0100, 4'd8);
        run_busy(1'b1, n);
        cmp++; if (n !== 16) begin bad++; $display("FAIL mul_busy_cycles: got %0d want 16", n); end
        cmp++; if (bif.bus_out !== 16'h0000) begin bad++; $display("FAIL mul_result: got %h want 0000", bif.bus_out); end
        cmp++; if ({bif.flag_z, bif.flag_c, bif.flag_n} !== 3'b110) begin bad++; $display("FAIL mul_flags: got %b want 110", {bif.flag_z, bif.flag_c, bif.flag_n}); end
        start(16'h0100, 4'd8);
        bif.alu_out_latch = 1'b1;
        cyc();
        bif.alu_out_latch = 1'b0;
        cyc(); cyc(); cyc();
        start(16'h0002, 4'd8);
        run_busy(1'b0, n);
        cmp++; if (n !== 16) begin bad++; $display("FAIL mul_restart_cycles: got %0d want 16", n); end
        cmp++; if (bif.bus_out !== 16'h0000) begin bad++; $display("FAIL mul_abort_pending: got %h want 0000", bif.bus_out); end
        latch();
        cmp++; if (bif.bus_out !== 16'h0200) begin bad++; $display("FAIL mul_restart_result: got %h want 0200", bif.bus_out); end
        cmp++; if ({bif.flag_z, bif.flag_c, bif.flag_n} !== 3'b000) begin bad++; $display("FAIL mul_restart_flags: got %b want 000", {bif.flag_z, bif.flag_c, bif.flag_n}); end
    endtask

    task automatic test_illegal();
        start(16'h1234, 4'hB);
        cyc();
        cmp++; if ({bif.op_err, bif.res_valid} !== 2'b11) begin bad++; $display("FAIL illegal_err_valid: got %b want 11", {bif.op_err, bif.res_valid}); end
        latch();
        cmp++; if (bif.bus_out !== 16'h0000) begin bad++; $display("FAIL illegal_result: got %h want 0000", bif.bus_out); end
        cmp++; if ({bif.flag_z, bif.flag_c, bif.flag_n} !== 3'b000) begin bad++; $display("FAIL illegal_flags: got %b want 000", {bif.flag_z, bif.flag_c, bif.flag_n}); end
        wr_a(16'h0100);
        start(16'h0001, 4'd0);
        cmp++; if (bif.op_err !== 1'b0) begin bad++; $display("FAIL illegal_clear: got %b want 0", bif.op_err); end
        cyc();
        latch();
        cmp++; if (bif.bus_out !== 16'h0101) begin bad++; $display("FAIL after_illegal_add: got %h want 0101", bif.bus_out); end
    endtask

    task automatic test_back_to_back();
        bif.bus_in = 16'h0007; bif.alu_op = 4'd0; bif.alu_in0 = 1'b1; bif.alu_in1 = 1'b1;
        cyc();
        bif.alu_in0 = 1'b0; bif.alu_in1 = 1'b0;
        cyc();
        latch();
        cmp++; if (bif.bus_out !== 16'h000E) begin bad++; $display("FAIL dual_strobe_add: got %h want 000e", bif.bus_out); end
        wr_a(16'hFFFF);
        start(16'h0001, 4'd0);
        cyc();
        bif.alu_out_latch = 1'b1;
        start(16'h00FF, 4'd4);
        bif.alu_out_latch = 1'b0;
        cmp++; if (bif.bus_out !== 16'h0000) begin bad++; $display("FAIL b2b_add_wrap: got %h want 0000", bif.bus_out); end
        cmp++; if ({bif.flag_z, bif.flag_c, bif.flag_n, bif.res_valid} !== 4'b1100) begin bad++; $display("FAIL b2b_add_flags: got %b want 1100", {bif.flag_z, bif.flag_c, bif.flag_n, bif.res_valid}); end
        cyc();
        latch();
        cmp++; if (bif.bus_out !== 16'hFF00) begin bad++; $display("FAIL b2b_xor: got %h want ff00", bif.bus_out); end
        cmp++; if ({bif.flag_z, bif.flag_c, bif.flag_n} !== 3'b001) begin bad++; $display("FAIL b2b_xor_flags: got %b want 001", {bif.flag_z, bif.flag_c, bif.flag_n}); end
    endtask

    task automatic test_rst_mid();
        wr_a(16'h0003);
        start(16'h0005, 4'd8);
        cyc(); cyc();
        bif.alu_out_latch = 1'b1;
        #2 rst = 1'b1;
        #1;
        cmp++; if ({bif.busy, bif.res_valid, bif.op_err} !== 3'b000) begin bad++; $display("FAIL rst_mid_status: got %b want 000", {bif.busy, bif.res_valid, bif.op_err}); end
        cmp++; if (bif.bus_out !== 16'h0000) begin bad++; $display("FAIL rst_mid_bus_out: got %h want 0000", bif.bus_out); end
        cmp++; if ({bif.flag_z, bif.flag_c, bif.flag_n} !== 3'b000) begin bad++; $display("FAIL rst_mid_flags: got %b want 000", {bif.flag_z, bif.flag_c, bif.flag_n}); end
        bif.alu_out_en = 1'b1;
        #1;
        cmp++; if (bif.bus_oe !== 1'b1) begin bad++; $display("FAIL rst_oe_high: got %b want 1", bif.bus_oe); end
        bif.alu_out_en = 1'b0;
        #1;
        cmp++; if (bif.bus_oe !== 1'b0) begin bad++; $display("FAIL rst_oe_low: got %b want 0", bif.bus_oe); end
        bif.alu_out_latch = 1'b0;
        cyc();
        rst = 1'b0;
        latch();
        cyc(); cyc();
        cmp++; if ({bif.busy, bif.res_valid, bif.bus_out} !== 18'h0) begin bad++; $display("FAIL rst_release_idle: got %h want 00000", {bif.busy, bif.res_valid, bif.bus_out}); end
    endtask

    initial begin
        rst = 1'b1;
        bif.bus_in = '0; bif.alu_op = '0; bif.alu_in0 = 1'b0; bif.alu_in1 = 1'b0;
        bif.alu_out_latch = 1'b0; bif.alu_out_en = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        test_reset();
        test_add();
        test_sub();
        test_shift();
        test_mul();
        test_illegal();
        test_back_to_back();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
